// File: rtl/axi_dma_burst_splitter_pkg.sv
// Shared types and constants for the AXI DMA burst splitter.
//   burst_e : AXI BURST encodings (FIXED/INCR/WRAP, 3 reserved)
//   state_e : command FSM states
//   Boundary4k, FixedMaxBeats : burst limits
package axi_dma_burst_splitter_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'd0,
    BurstIncr  = 2'd1,
    BurstWrap  = 2'd2,
    BurstRsvd  = 2'd3
  } burst_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCalc,
    StEmit,
    StDone
  } state_e;

  localparam int unsigned Boundary4k    = 4096;
  localparam int unsigned FixedMaxBeats = 16;

endpackage

// File: rtl/axi_dma_burst_splitter_if.sv
// Command and descriptor bus of the AXI DMA burst splitter.
//   cmd_*  : per-channel command inputs (packed, channel i at slice i), cmd_ready grant,
//            cmd_done / cmd_err completion pulses
//   desc_* : valid/ready descriptor stream to the read/write engines
// Modports: slave = splitter side, master = command source / descriptor sink side.
interface axi_dma_burst_splitter_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_WD = 32
);
  localparam int unsigned CH_WD = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         cmd_valid;
  logic [NUM_CH-1:0]         cmd_ready;
  logic [NUM_CH*ADDR_WD-1:0] cmd_src_addr;
  logic [NUM_CH*ADDR_WD-1:0] cmd_dst_addr;
  logic [NUM_CH*2-1:0]       cmd_burst;
  logic [NUM_CH*ADDR_WD-1:0] cmd_len;
  logic [NUM_CH*3-1:0]       cmd_size;
  logic                      desc_valid;
  logic                      desc_ready;
  logic [ADDR_WD-1:0]        desc_src_addr;
  logic [ADDR_WD-1:0]        desc_dst_addr;
  logic [7:0]                desc_len;
  logic [2:0]                desc_size;
  logic [1:0]                desc_burst;
  logic [CH_WD-1:0]          desc_ch;
  logic                      desc_last;
  logic [NUM_CH-1:0]         cmd_done;
  logic [NUM_CH-1:0]         cmd_err;

  modport slave (
    input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size, desc_ready,
    output cmd_ready, desc_valid, desc_src_addr, desc_dst_addr, desc_len, desc_size,
           desc_burst, desc_ch, desc_last, cmd_done, cmd_err
  );

  modport master (
    output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size, desc_ready,
    input  cmd_ready, desc_valid, desc_src_addr, desc_dst_addr, desc_len, desc_size,
           desc_burst, desc_ch, desc_last, cmd_done, cmd_err
  );

endinterface

// File: rtl/axi_dma_burst_splitter_rr_arbiter.sv
// Pointer-based round-robin arbiter.
//   req         : request vector
//   advance     : grant consumed this cycle; pointer moves to grant_idx+1 (mod NUM_CH)
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : index of granted requester
//   grant_valid : any request present
module axi_dma_burst_splitter_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_WD  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_WD-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [CH_WD-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, scanning upwards with wrap.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr_q) + i) % NUM_CH;
      if (!grant_valid && req[CH_WD'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_WD'(idx);
      end
    end
  end

  assign grant = grant_valid ? (NUM_CH'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/axi_dma_burst_splitter.sv
// Multi-channel DMA command front end. Accepts per-channel copy commands via round-robin,
// validates them and splits each into AXI-legal burst descriptors (at most MAX_BURST beats,
// never crossing a 4KB page on either side; FIXED capped at 16; WRAP issued as one burst).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : command inputs / cmd_ready / cmd_done / cmd_err and descriptor stream
module axi_dma_burst_splitter
  import axi_dma_burst_splitter_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_WD   = 32,
  parameter int unsigned DATA_WD   = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                     clk,
  input logic                     rst,
  axi_dma_burst_splitter_if.slave bus
);

  localparam int unsigned CH_WD     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_SIZE  = $clog2(DATA_WD / 8);
  localparam int unsigned FIXED_CAP = (MAX_BURST < FixedMaxBeats) ? MAX_BURST : FixedMaxBeats;

  state_e             state_q, state_d;
  logic [CH_WD-1:0]   ch_q, ch_d;
  logic [ADDR_WD-1:0] src_q, src_d;
  logic [ADDR_WD-1:0] dst_q, dst_d;
  logic [ADDR_WD-1:0] rem_q, rem_d;
  logic [2:0]         size_q, size_d;
  burst_e             burst_q, burst_d;
  logic [8:0]         beats_q, beats_d;

  logic [NUM_CH-1:0]  grant;
  logic [CH_WD-1:0]   grant_idx;
  logic               grant_valid;
  logic               accept;

  logic [NUM_CH-1:0]  cmd_ready;
  logic [NUM_CH-1:0]  cmd_done;
  logic [NUM_CH-1:0]  cmd_err;
  logic               desc_valid;
  logic [ADDR_WD-1:0] desc_src_addr;
  logic [ADDR_WD-1:0] desc_dst_addr;
  logic [7:0]         desc_len;
  logic [2:0]         desc_size;
  logic [1:0]         desc_burst;
  logic [CH_WD-1:0]   desc_ch;
  logic               desc_last;

  axi_dma_burst_splitter_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_WD  (CH_WD)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.cmd_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign accept = (state_q == StIdle) && grant_valid && !rst;

  // Operands of the granted channel.
  logic [ADDR_WD-1:0] sel_src, sel_dst, sel_len;
  logic [1:0]         sel_burst;
  logic [2:0]         sel_size;

  assign sel_src   = bus.cmd_src_addr[grant_idx*ADDR_WD +: ADDR_WD];
  assign sel_dst   = bus.cmd_dst_addr[grant_idx*ADDR_WD +: ADDR_WD];
  assign sel_len   = bus.cmd_len[grant_idx*ADDR_WD +: ADDR_WD];
  assign sel_burst = bus.cmd_burst[grant_idx*2 +: 2];
  assign sel_size  = bus.cmd_size[grant_idx*3 +: 3];

  // Command legality.
  logic [ADDR_WD-1:0] align_mask;
  logic               wrap_len_ok;
  logic               cmd_bad;

  assign align_mask  = ~({ADDR_WD{1'b1}} << size_q);
  assign wrap_len_ok = (rem_q == ADDR_WD'(2)) || (rem_q == ADDR_WD'(4)) ||
                       (rem_q == ADDR_WD'(8)) || (rem_q == ADDR_WD'(16));
  assign cmd_bad     = (32'(size_q) > MAX_SIZE) || (burst_q == BurstRsvd) ||
                       (|(src_q & align_mask)) || (|(dst_q & align_mask)) ||
                       ((burst_q == BurstWrap) && !wrap_len_ok);

  // Beats left before each side reaches its next 4KB page; 13 bits holds a full page.
  logic [12:0] src_room, dst_room, incr_cap, cap;
  logic [8:0]  beats_calc;

  assign src_room = (13'(Boundary4k) - {1'b0, src_q[11:0]}) >> size_q;
  assign dst_room = (13'(Boundary4k) - {1'b0, dst_q[11:0]}) >> size_q;

  always_comb begin
    incr_cap = 13'(MAX_BURST);
    if (src_room < incr_cap) incr_cap = src_room;
    if (dst_room < incr_cap) incr_cap = dst_room;
    cap = (burst_q == BurstFixed) ? 13'(FIXED_CAP) : incr_cap;
    // WRAP length was already restricted to 2..16 in the check state.
    if (burst_q == BurstWrap) begin
      beats_calc = 9'(rem_q);
    end else if (rem_q < ADDR_WD'(cap)) begin
      beats_calc = 9'(rem_q);
    end else begin
      beats_calc = 9'(cap);
    end
  end

  logic [NUM_CH-1:0] ch_onehot;
  assign ch_onehot = NUM_CH'(1) << ch_q;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    src_d         = src_q;
    dst_d         = dst_q;
    rem_d         = rem_q;
    size_d        = size_q;
    burst_d       = burst_q;
    beats_d       = beats_q;
    cmd_ready     = '0;
    cmd_done      = '0;
    cmd_err       = '0;
    desc_valid    = 1'b0;
    desc_src_addr = '0;
    desc_dst_addr = '0;
    desc_len      = '0;
    desc_size     = '0;
    desc_burst    = '0;
    desc_ch       = '0;
    desc_last     = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          cmd_ready = grant;
          ch_d      = grant_idx;
          src_d     = sel_src;
          dst_d     = sel_dst;
          rem_d     = sel_len;
          size_d    = sel_size;
          burst_d   = burst_e'(sel_burst);
          state_d   = StCheck;
        end
      end
      StCheck: begin
        if (cmd_bad) begin
          cmd_err = ch_onehot;
          state_d = StIdle;
        end else if (rem_q == '0) begin
          cmd_done = ch_onehot;
          state_d  = StIdle;
        end else begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        beats_d = beats_calc;
        state_d = StEmit;
      end
      StEmit: begin
        desc_valid    = 1'b1;
        desc_src_addr = src_q;
        desc_dst_addr = dst_q;
        desc_len      = 8'(beats_q - 9'd1);
        desc_size     = size_q;
        desc_burst    = burst_q;
        desc_ch       = ch_q;
        desc_last     = (rem_q == ADDR_WD'(beats_q));
        if (bus.desc_ready) begin
          rem_d = rem_q - ADDR_WD'(beats_q);
          if (burst_q == BurstIncr) begin
            src_d = src_q + (ADDR_WD'(beats_q) << size_q);
            dst_d = dst_q + (ADDR_WD'(beats_q) << size_q);
          end
          state_d = (rem_d == '0) ? StDone : StCalc;
        end
      end
      StDone: begin
        cmd_done = ch_onehot;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      burst_q <= BurstFixed;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beats_q <= beats_d;
    end
  end

  // Nothing is granted while reset is held.
  assign bus.cmd_ready     = rst ? '0 : cmd_ready;
  assign bus.cmd_done      = cmd_done;
  assign bus.cmd_err       = cmd_err;
  assign bus.desc_valid    = desc_valid;
  assign bus.desc_src_addr = desc_src_addr;
  assign bus.desc_dst_addr = desc_dst_addr;
  assign bus.desc_len      = desc_len;
  assign bus.desc_size     = desc_size;
  assign bus.desc_burst    = desc_burst;
  assign bus.desc_ch       = desc_ch;
  assign bus.desc_last     = desc_last;

endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
module tb_axi_dma_burst_splitter;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned ADDR_WD   = 32;
  localparam int unsigned DATA_WD   = 32;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned MAX_SIZE  = 2;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [8:0]  beats;
    logic        last;
  } desc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_dma_burst_splitter_if #(.NUM_CH(NUM_CH), .ADDR_WD(ADDR_WD)) bus ();

  axi_dma_burst_splitter #(
    .NUM_CH    (NUM_CH),
    .ADDR_WD   (ADDR_WD),
    .DATA_WD   (DATA_WD),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int tb_ptr = 0;

  logic [31:0] c_src[NUM_CH];
  logic [31:0] c_dst[NUM_CH];
  logic [31:0] c_len[NUM_CH];
  logic [1:0]  c_burst[NUM_CH];
  logic [2:0]  c_size[NUM_CH];
  desc_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_cmd(input int ch, input logic [31:0] src, input logic [31:0] dst,
                         input logic [1:0] burst, input logic [31:0] len, input logic [2:0] size);
    c_src[ch]   = src;
    c_dst[ch]   = dst;
    c_len[ch]   = len;
    c_burst[ch] = burst;
    c_size[ch]  = size;
    bus.cmd_src_addr[ch*ADDR_WD +: ADDR_WD] = src;
    bus.cmd_dst_addr[ch*ADDR_WD +: ADDR_WD] = dst;
    bus.cmd_len[ch*ADDR_WD +: ADDR_WD]      = len;
    bus.cmd_burst[ch*2 +: 2]                = burst;
    bus.cmd_size[ch*3 +: 3]                 = size;
    bus.cmd_valid[ch]                       = 1'b1;
  endtask

  // Reference: the list of descriptors the command should produce, by plain page arithmetic.
  task automatic build_model(input int ch, output bit is_err);
    longint unsigned bytes, s, d, rem, cap, room, beats;
    bytes  = 64'd1 << c_size[ch];
    is_err = (c_size[ch] > MAX_SIZE) || (c_burst[ch] == 2'd3) ||
             ((c_src[ch] % bytes) != 0) || ((c_dst[ch] % bytes) != 0) ||
             ((c_burst[ch] == 2'd2) && !(c_len[ch] inside {2, 4, 8, 16}));
    exp_q.delete();
    if (is_err) return;
    s   = c_src[ch];
    d   = c_dst[ch];
    rem = c_len[ch];
    while (rem != 0) begin
      if (c_burst[ch] == 2'd2) begin
        beats = rem;
      end else begin
        cap = (c_burst[ch] == 2'd0) ? ((MAX_BURST < 16) ? MAX_BURST : 16) : MAX_BURST;
        if (c_burst[ch] == 2'd1) begin
          room = (4096 - (s % 4096)) / bytes;
          if (room < cap) cap = room;
          room = (4096 - (d % 4096)) / bytes;
          if (room < cap) cap = room;
        end
        beats = (rem < cap) ? rem : cap;
      end
      rem -= beats;
      exp_q.push_back('{src: s[31:0], dst: d[31:0], beats: beats[8:0], last: (rem == 0)});
      if (c_burst[ch] == 2'd1) begin
        s = (s + beats * bytes) % (64'd1 << 32);
        d = (d + beats * bytes) % (64'd1 << 32);
      end
    end
  endtask

  function automatic int pick_rr(input logic [NUM_CH-1:0] m);
    for (int i = 0; i < NUM_CH; i++) begin
      int j;
      j = (tb_ptr + i) % NUM_CH;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  // Call just after a falling edge with the command(s) already presented.
  task automatic serve(input int ch, input bit stall_first);
    bit    is_err, finished, hold, first_seen;
    int    w, cyc, stalls, n_exp, n_got;
    desc_t e;
    logic [31:0] sv_src, sv_dst;
    logic [7:0]  sv_len;
    logic        sv_last;
    finished = 0; hold = 0; first_seen = 0; cyc = 0; stalls = 0; n_got = 0;
    sv_src = '0; sv_dst = '0; sv_len = '0; sv_last = 1'b0;
    #1;
    w = 0;
    while (bus.cmd_ready == '0 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check("grant", 64'(bus.cmd_ready), 64'(1) << ch);
    build_model(ch, is_err);
    n_exp = exp_q.size();
    @(posedge clk); #1;
    bus.cmd_valid[ch] = 1'b0;
    tb_ptr = (ch + 1) % NUM_CH;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall_first && stalls < 5 && bus.desc_valid) begin
        bus.desc_ready = 1'b0;
        stalls++;
      end else begin
        bus.desc_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      check("ready_busy", 64'(bus.cmd_ready), 64'(0));
      if (hold) begin
        check("stable_valid", 64'(bus.desc_valid), 64'(1));
        check("stable_src", 64'(bus.desc_src_addr), 64'(sv_src));
        check("stable_dst", 64'(bus.desc_dst_addr), 64'(sv_dst));
        check("stable_len", 64'(bus.desc_len), 64'(sv_len));
        check("stable_last", 64'(bus.desc_last), 64'(sv_last));
      end
      hold = 0;
      if (bus.desc_valid) begin
        if (!first_seen) check("latency", 64'(cyc), 64'(3));
        first_seen = 1;
        if (bus.desc_ready) begin
          n_got++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("desc_src", 64'(bus.desc_src_addr), 64'(e.src));
            check("desc_dst", 64'(bus.desc_dst_addr), 64'(e.dst));
            check("desc_len", 64'(bus.desc_len), 64'(e.beats - 9'd1));
            check("desc_size", 64'(bus.desc_size), 64'(c_size[ch]));
            check("desc_burst", 64'(bus.desc_burst), 64'(c_burst[ch]));
            check("desc_ch", 64'(bus.desc_ch), 64'(ch));
            check("desc_last", 64'(bus.desc_last), 64'(e.last));
          end
        end else begin
          hold    = 1;
          sv_src  = bus.desc_src_addr;
          sv_dst  = bus.desc_dst_addr;
          sv_len  = bus.desc_len;
          sv_last = bus.desc_last;
        end
      end
      if ((|bus.cmd_done) || (|bus.cmd_err)) begin
        check("cmd_done", 64'(bus.cmd_done), is_err ? 64'(0) : (64'(1) << ch));
        check("cmd_err", 64'(bus.cmd_err), is_err ? (64'(1) << ch) : 64'(0));
        finished = 1;
      end
    end
    check("finished", 64'(finished), 64'(1));
    check("desc_count", 64'(n_got), 64'(n_exp));
    exp_q.delete();
    bus.desc_ready = 1'b0;
    @(negedge clk); #1;
    check("pulse_width", 64'({bus.cmd_done, bus.cmd_err}), 64'(0));
  endtask

  task automatic rand_cmd(input int ch);
    logic [31:0] r, src, dst, len, mask;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          sel;
    sel  = $urandom_range(0, 9);
    size = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    sel  = $urandom_range(0, 15);
    burst = (sel == 0) ? 2'd3 : (sel < 4) ? 2'd0 : (sel < 7) ? 2'd2 : 2'd1;
    if (burst == 2'd2) begin
      sel = $urandom_range(0, 4);
      len = (sel == 0) ? 32'($urandom_range(0, 20)) : (32'd2 << $urandom_range(0, 3));
    end else begin
      len = ($urandom_range(0, 20) == 0) ? 32'd0 : 32'($urandom_range(1, 50));
    end
    mask = (32'd1 << size) - 32'd1;
    r = $urandom;
    src = {r[31:12], 12'($urandom_range(0, 4095))};
    if ($urandom_range(0, 1) == 1) src[11:0] = 12'hFFF - 12'($urandom_range(0, 255));
    if ($urandom_range(0, 7) != 0) src = src & ~mask;
    r = $urandom;
    dst = {r[31:12], 12'($urandom_range(0, 4095))};
    if ($urandom_range(0, 1) == 1) dst[11:0] = 12'hFFF - 12'($urandom_range(0, 255));
    if ($urandom_range(0, 7) != 0) dst = dst & ~mask;
    set_cmd(ch, src, dst, burst, len, size);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] mask;
    int ch, w;
    bus.cmd_valid    = '0;
    bus.cmd_src_addr = '0;
    bus.cmd_dst_addr = '0;
    bus.cmd_len      = '0;
    bus.cmd_burst    = '0;
    bus.cmd_size     = '0;
    bus.desc_ready   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmd_valid = 4'b0101;
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_desc_valid", 64'(bus.desc_valid), 64'(0));
    check("rst_desc_src", 64'(bus.desc_src_addr), 64'(0));
    check("rst_desc_len", 64'(bus.desc_len), 64'(0));
    check("rst_desc_last", 64'(bus.desc_last), 64'(0));
    check("rst_done_err", 64'({bus.cmd_done, bus.cmd_err}), 64'(0));
    bus.cmd_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Round-robin between ch0 and ch2 from pointer 0, then both again.
    set_cmd(0, 32'd128, 32'd512, 2'd1, 32'd32, 3'd2);
    set_cmd(2, 32'h40, 32'h80, 2'd2, 32'd8, 3'd2);
    for (int k = 0; k < 2; k++) begin
      mask = 4'b0101;
      while (mask != '0) begin
        ch = pick_rr(mask);
        serve(ch, 1'b0);
        mask[ch] = 1'b0;
      end
      set_cmd(0, 32'd128, 32'd512, 2'd1, 32'd32, 3'd2);
      set_cmd(2, 32'h40, 32'h80, 2'd2, 32'd8, 3'd2);
      if (k == 1) bus.cmd_valid = '0;
    end

    // Directed cases.
    set_cmd(0, 32'h0FF0, 32'h2000, 2'd1, 32'd8, 3'd2);
    serve(0, 1'b0);
    set_cmd(1, 32'd340, 32'd124, 2'd0, 32'd40, 3'd2);
    serve(1, 1'b1);
    set_cmd(1, 32'd341, 32'd124, 2'd0, 32'd40, 3'd2);
    serve(1, 1'b0);
    set_cmd(2, 32'h40, 32'h80, 2'd2, 32'd6, 3'd2);
    serve(2, 1'b0);
    set_cmd(3, 32'h100, 32'h200, 2'd1, 32'd0, 3'd2);
    serve(3, 1'b0);
    set_cmd(3, 32'hFFFF_FFC0, 32'h0000_0FC0, 2'd1, 32'd40, 3'd2);
    serve(3, 1'b0);

    // Random multi-channel rounds.
    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) if (mask[c]) rand_cmd(c);
      while (mask != '0) begin
        ch = pick_rr(mask);
        serve(ch, 1'b0);
        mask[ch] = 1'b0;
      end
    end

    // Reset in the middle of a command.
    set_cmd(1, 32'h100, 32'h200, 2'd1, 32'd64, 3'd2);
    w = 0;
    do begin
      @(negedge clk); #1; w++;
    end while (!bus.desc_valid && w < 10);
    check("pre_rst_valid", 64'(bus.desc_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus.desc_valid), 64'(0));
    check("mid_rst_ready", 64'(bus.cmd_ready), 64'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("mid_rst_done", 64'({bus.cmd_done, bus.cmd_err}), 64'(0));
      check("mid_rst_ready", 64'(bus.cmd_ready), 64'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    tb_ptr = 0;
    serve(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
